// File: rtl/lidar_scan_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lidar_scan_tx : builds one LiDAR scan packet from a local sample buffer
//                 and serialises it as 8N1 UART.   Revision: 1.0
// ============================================================================
module lidar_scan_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int MAX_SAMPLES  = 16,
   parameter int GAP_BITS     = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [$clog2(MAX_SAMPLES)-1:0] wr_addr,
   input  logic [15:0]                    wr_data,
   input  logic                           start,
   input  logic [7:0]                     ct,
   input  logic [7:0]                     lsn,
   input  logic [15:0]                    fsa,
   input  logic [15:0]                    lsa,
   output logic                           busy,
   output logic                           done,
   output logic                           tx
);

   localparam int          c_AW       = $clog2(MAX_SAMPLES);
   localparam logic [15:0] c_CLK_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] c_GAP_LAST = 16'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [7:0]  c_MAX_LSN  = 8'(MAX_SAMPLES);
   localparam bit          c_HAS_GAP  = (GAP_BITS > 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            r_state;
   logic [15:0]       r_mem [MAX_SAMPLES];
   logic [15:0]       r_rd_data;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [15:0]       r_clk_cnt;
   logic [15:0]       r_gap_cnt;
   logic [2:0]        r_bit_idx;
   logic [9:0]        r_byte_idx;
   logic [9:0]        r_last_idx;
   logic [7:0]        r_shift;
   logic [7:0]        r_ct;
   logic [7:0]        r_lsn;
   logic [15:0]       r_fsa;
   logic [15:0]       r_lsa;
   logic              r_tx;
   logic              r_busy;
   logic              r_done;

   logic              w_bit_end;
   logic              w_load;
   logic [7:0]        w_eff_lsn;
   logic [9:0]        w_nxt_idx;
   logic [7:0]        w_nxt_byte;

   assign w_bit_end = (r_clk_cnt == c_CLK_LAST);
   assign w_eff_lsn = (lsn > c_MAX_LSN) ? c_MAX_LSN : lsn;

   // Next byte to send; sample bytes come from the registered buffer read,
   // which is stable long before the current byte's stop bit ends.
   always_comb begin
      w_nxt_idx  = r_byte_idx + 10'd1;
      w_nxt_byte = w_nxt_idx[0] ? r_rd_data[15:8] : r_rd_data[7:0];
      case (w_nxt_idx)
         10'd1:   w_nxt_byte = 8'h55;
         10'd2:   w_nxt_byte = r_ct;
         10'd3:   w_nxt_byte = r_lsn;
         10'd4:   w_nxt_byte = r_fsa[7:0];
         10'd5:   w_nxt_byte = r_fsa[15:8];
         10'd6:   w_nxt_byte = r_lsa[7:0];
         10'd7:   w_nxt_byte = r_lsa[15:8];
         default: ;
      endcase
   end

   always_comb begin
      w_load = 1'b0;
      if (w_bit_end) begin
         if (r_state == S_STOP && r_byte_idx != r_last_idx && !c_HAS_GAP)
            w_load = 1'b1;
         if (r_state == S_GAP && r_gap_cnt == c_GAP_LAST)
            w_load = 1'b1;
      end
   end

   // Buffer is frozen while a packet is in flight.
   always_ff @(posedge clk) begin
      if (wr_en && !r_busy && (32'(wr_addr) < MAX_SAMPLES))
         r_mem[wr_addr] <= wr_data;
      r_rd_data <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_clk_cnt  <= 16'd0;
         r_gap_cnt  <= 16'd0;
         r_bit_idx  <= 3'd0;
         r_byte_idx <= 10'd0;
         r_last_idx <= 10'd0;
         r_rd_ptr   <= '0;
         r_shift    <= 8'd0;
         r_ct       <= 8'd0;
         r_lsn      <= 8'd0;
         r_fsa      <= 16'd0;
         r_lsa      <= 16'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ct       <= ct;
                  r_lsn      <= w_eff_lsn;
                  r_fsa      <= fsa;
                  r_lsa      <= lsa;
                  r_last_idx <= 10'd7 + {1'b0, w_eff_lsn, 1'b0};
                  r_byte_idx <= 10'd0;
                  r_rd_ptr   <= '0;
                  r_shift    <= 8'hAA;
                  r_clk_cnt  <= 16'd0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 16'd0;
                  r_bit_idx <= 3'd0;
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 16'd0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 16'd0;
                  if (r_byte_idx == r_last_idx) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end else if (c_HAS_GAP) begin
                     r_gap_cnt <= 16'd0;
                     r_state   <= S_GAP;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_GAP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= 16'd0;
                  r_gap_cnt <= r_gap_cnt + 16'd1;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Entry into the start bit of every byte after the first.
         if (w_load) begin
            r_tx       <= 1'b0;
            r_byte_idx <= w_nxt_idx;
            r_shift    <= w_nxt_byte;
            r_state    <= S_START;
            if (w_nxt_idx >= 10'd8 && w_nxt_idx[0])
               r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lidar_scan_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_lidar_scan_tx : randomized packet checks against a byte/waveform model.
//                    Revision: 1.0
// ============================================================================
module tb_lidar_scan_tx;

   localparam int CPB  = 4;
   localparam int MAXS = 16;

   typedef logic [7:0] byte_q_t [$];
   typedef logic       bit_q_t  [$];

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        wr_en   = 1'b0;
   logic [3:0]  wr_addr = 4'd0;
   logic [15:0] wr_data = 16'd0;
   logic        start   = 1'b0;
   logic [7:0]  ct      = 8'd0;
   logic [7:0]  lsn     = 8'd0;
   logic [15:0] fsa     = 16'd0;
   logic [15:0] lsa     = 16'd0;
   logic        busy0, done0, tx0;
   logic        busy2, done2, tx2;

   logic [15:0] model_mem [MAXS];
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   lidar_scan_tx #(.CLKS_PER_BIT(CPB), .MAX_SAMPLES(MAXS), .GAP_BITS(0)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .ct(ct), .lsn(lsn), .fsa(fsa), .lsa(lsa),
      .busy(busy0), .done(done0), .tx(tx0));

   lidar_scan_tx #(.CLKS_PER_BIT(CPB), .MAX_SAMPLES(MAXS), .GAP_BITS(2)) dut_g (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .ct(ct), .lsn(lsn), .fsa(fsa), .lsa(lsa),
      .busy(busy2), .done(done2), .tx(tx2));

   function automatic byte_q_t build_bytes(input logic [7:0] pct, input logic [7:0] plsn,
                                           input logic [15:0] pfsa, input logic [15:0] plsa);
      byte_q_t q;
      int      eff;
      eff = (int'(plsn) > MAXS) ? MAXS : int'(plsn);
      q = {8'hAA, 8'h55, pct, 8'(eff), pfsa[7:0], pfsa[15:8], plsa[7:0], plsa[15:8]};
      for (int i = 0; i < eff; i++) begin
         q.push_back(model_mem[i][7:0]);
         q.push_back(model_mem[i][15:8]);
      end
      return q;
   endfunction

   // Line level per clock cycle: start, 8 data bits LSB first, stop, optional gap.
   function automatic bit_q_t build_wave(input byte_q_t b, input int gap);
      bit_q_t     w;
      logic [7:0] v;
      for (int k = 0; k < b.size(); k++) begin
         v = b[k];
         for (int c = 0; c < CPB; c++) w.push_back(1'b0);
         for (int j = 0; j < 8; j++)
            for (int c = 0; c < CPB; c++) w.push_back(v[j]);
         for (int c = 0; c < CPB; c++) w.push_back(1'b1);
         if (k != b.size() - 1)
            for (int c = 0; c < gap * CPB; c++) w.push_back(1'b1);
      end
      return w;
   endfunction

   function automatic byte_q_t decode(input bit_q_t w, input int n, input int gap);
      byte_q_t    q;
      logic [7:0] v;
      int         idx;
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 8; j++) begin
            idx  = k * (10 + gap) * CPB + CPB * (j + 1) + CPB / 2;
            v[j] = (idx < w.size()) ? w[idx] : 1'bx;
         end
         q.push_back(v);
      end
      return q;
   endfunction

   task automatic wait_idle();
      int n = 0;
      while ((busy0 !== 1'b0 || busy2 !== 1'b0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle: busy0=%b busy2=%b still set, required 0 within 5000 cycles", busy0, busy2);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic write_sample(input int a, input logic [15:0] d);
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic fill_random();
      for (int a = 0; a < MAXS; a++) write_sample(a, 16'($urandom));
   endtask

   task automatic pulse_start(input logic [7:0] pct, input logic [7:0] plsn,
                              input logic [15:0] pfsa, input logic [15:0] plsa,
                              input bit with_wr, input logic [15:0] wd);
      @(negedge clk);
      ct = pct; lsn = plsn; fsa = pfsa; lsa = plsa; start = 1'b1;
      if (with_wr) begin
         wr_en = 1'b1; wr_addr = 4'd0; wr_data = wd;
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic run_packet(input bit g, input logic [7:0] pct, input logic [7:0] plsn,
                             input logic [15:0] pfsa, input logic [15:0] plsa,
                             input bit with_wr, input logic [15:0] wd, input int inject_at,
                             input string name, output int done_at, output byte_q_t got);
      byte_q_t exp;
      bit_q_t  wave, tr;
      int      n, tx_err, busy_err, pulses, first_bad, byte_err;
      logic    t, b, d;
      wait_idle();
      if (with_wr) model_mem[0] = wd;
      exp = build_bytes(pct, plsn, pfsa, plsa);
      wave = build_wave(exp, g ? 2 : 0);
      n = wave.size();
      tx_err = 0; busy_err = 0; pulses = 0; first_bad = -1; done_at = -1; byte_err = 0;
      t = 1'b0; b = 1'b0;
      pulse_start(pct, plsn, pfsa, plsa, with_wr, wd);
      for (int c = 0; c <= n + 2; c++) begin
         if (c > 0) @(negedge clk);
         t = g ? tx2 : tx0;
         b = g ? busy2 : busy0;
         d = g ? done2 : done0;
         if (c == inject_at) begin
            start = 1'b1; ct = ~pct; lsn = 8'd1;
            wr_en = 1'b1; wr_addr = 4'd1; wr_data = ~model_mem[1];
         end else if (c == inject_at + 1) begin
            start = 1'b0; wr_en = 1'b0;
         end
         if (c < n) begin
            tr.push_back(t);
            if (t !== wave[c]) begin
               if (tx_err == 0) first_bad = c;
               tx_err++;
            end
            if (b !== 1'b1) busy_err++;
         end
         if (d === 1'b1) begin
            pulses++;
            if (done_at < 0) done_at = c;
         end
      end
      vectors++;
      if (tx_err != 0) begin
         miscompares++;
         $display("FAIL %s tx_wave: %0d bad cycles, first at cycle %0d (got %b, required %b)",
                  name, tx_err, first_bad, tr[first_bad], wave[first_bad]);
      end
      vectors++;
      if (busy_err != 0) begin
         miscompares++;
         $display("FAIL %s busy: low in %0d packet cycles, required 0", name, busy_err);
      end
      vectors++;
      if (done_at != n) begin
         miscompares++;
         $display("FAIL %s done_time: got cycle %0d, required %0d", name, done_at, n);
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL %s done_pulses: got %0d, required 1", name, pulses);
      end
      vectors++;
      if (t !== 1'b1 || b !== 1'b0) begin
         miscompares++;
         $display("FAIL %s idle_after: tx=%b busy=%b, required tx=1 busy=0", name, t, b);
      end
      got = decode(tr, exp.size(), g ? 2 : 0);
      for (int i = 0; i < exp.size(); i++)
         if (got[i] !== exp[i]) byte_err++;
      vectors++;
      if (byte_err != 0) begin
         miscompares++;
         $display("FAIL %s bytes: %0d of %0d decoded bytes wrong (byte3 got %h, required %h)",
                  name, byte_err, exp.size(), got[3], exp[3]);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 ||
             tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) bad++;
      end
      reset = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 ||
             tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL reset_idle: %0d cycles not idle (tx0=%b busy0=%b done0=%b), required tx=1 busy=0 done=0",
                  bad, tx0, busy0, done0);
      end
   endtask

   task automatic test_basic();
      byte_q_t    got;
      int         da;
      logic [7:0] lit [12];
      int         bad = 0;
      lit = '{8'hAA, 8'h55, 8'h2A, 8'h02, 8'h01, 8'hA1, 8'h03, 8'hB2, 8'h34, 8'h12, 8'hCD, 8'h0B};
      write_sample(0, 16'h1234);
      write_sample(1, 16'h0BCD);
      run_packet(1'b0, 8'h2A, 8'd2, 16'hA101, 16'hB203, 1'b0, 16'h0, -1, "basic", da, got);
      for (int i = 0; i < 12; i++) if (got[i] !== lit[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL basic_literal: %0d bytes differ (byte8 got %h, required 34)", bad, got[8]);
      end
      vectors++;
      if (da != 480) begin
         miscompares++;
         $display("FAIL basic_480: done at %0d, required 480", da);
      end
   endtask

   task automatic test_random();
      byte_q_t got;
      int      da;
      for (int i = 0; i < 5; i++) begin
         fill_random();
         run_packet(1'b0, 8'($urandom), 8'($urandom_range(0, 20)), 16'($urandom), 16'($urandom),
                    (i == 2), 16'($urandom), -1, $sformatf("random%0d", i), da, got);
      end
   endtask

   task automatic test_clamp_empty();
      byte_q_t got;
      int      da;
      fill_random();
      run_packet(1'b0, 8'h11, 8'd40, 16'h0102, 16'h0304, 1'b0, 16'h0, -1, "clamp", da, got);
      vectors++;
      if (got[3] !== 8'h10 || da != 1600) begin
         miscompares++;
         $display("FAIL clamp: lsn byte %h done %0d, required 10 and 1600", got[3], da);
      end
      run_packet(1'b0, 8'h22, 8'd0, 16'h0506, 16'h0708, 1'b0, 16'h0, -1, "empty", da, got);
      vectors++;
      if (da != 320) begin
         miscompares++;
         $display("FAIL empty: done at %0d, required 320", da);
      end
   endtask

   task automatic test_busy();
      byte_q_t got;
      int      da;
      int      bad = 0;
      run_packet(1'b0, 8'h5A, 8'd2, 16'h1357, 16'h2468, 1'b0, 16'h0, 200, "busy_inject", da, got);
      repeat (100) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL busy_no_queue: %0d cycles active after packet, required 0", bad);
      end
      run_packet(1'b0, 8'h5B, 8'd2, 16'h1111, 16'h2222, 1'b0, 16'h0, -1, "busy_frozen", da, got);
   endtask

   task automatic test_gap();
      byte_q_t got;
      int      da;
      run_packet(1'b1, 8'h33, 8'd0, 16'hBEEF, 16'hCAFE, 1'b0, 16'h0, -1, "gap", da, got);
      vectors++;
      if (da != 376) begin
         miscompares++;
         $display("FAIL gap_376: done at %0d, required 376", da);
      end
      run_packet(1'b1, 8'h44, 8'd3, 16'h0F0F, 16'hF0F0, 1'b0, 16'h0, -1, "gap_samples", da, got);
   endtask

   task automatic test_reset_mid();
      byte_q_t got;
      int      da;
      int      bad = 0;
      wait_idle();
      pulse_start(8'h77, 8'd3, 16'h1111, 16'h2222, 1'b0, 16'h0);
      for (int c = 1; c <= 130; c++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: tx0=%b busy0=%b done0=%b tx2=%b busy2=%b, required 1 0 0 1 0",
                  tx0, busy0, done0, tx2, busy2);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet: %0d active cycles after abort, required 0", bad);
      end
      run_packet(1'b0, 8'h99, 8'd3, 16'h4321, 16'h8765, 1'b0, 16'h0, -1, "post_reset", da, got);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_clamp_empty();
      test_busy();
      test_gap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
